// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: queues range-checked pixel writes in a small FIFO and
// streams them to a stallable framebuffer port, with a full-screen fill mode.
module pixel_write_buffer #(
    parameter int DEPTH    = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  color,
    output logic        ready,
    input  logic        fillReq,
    input  logic [2:0]  fillColor,
    input  logic        memBusy,
    output logic [14:0] memAddr,
    output logic [2:0]  memData,
    output logic        memWren,
    output logic        fillDone,
    output logic [7:0]  dropCount
);
    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = PW + 1;
    localparam int LAST_ADDR = SCREEN_W * SCREEN_H - 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t        state_q, state_d;
    logic [17:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          mem_wren_q, mem_wren_d;
    logic [14:0]   mem_addr_q, mem_addr_d;
    logic [2:0]    mem_data_q, mem_data_d;
    logic          fill_done_q, fill_done_d;
    logic          fill_pending_q, fill_pending_d;
    logic [2:0]    fill_color_q, fill_color_d;
    logic [7:0]    drop_count_q;

    logic          fifo_full, fifo_empty, accept, in_range, push, drop;
    logic          out_free, pop, fill_start;
    logic [14:0]   pix_addr;
    logic [17:0]   fifo_head;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign ready      = !fifo_full && (state_q == IDLE) && !fill_pending_q && !reset;
    assign accept     = plot && ready;
    assign in_range   = (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
    assign push       = accept && in_range;
    assign drop       = accept && !in_range;

    // y*160 + x without a multiplier
    assign pix_addr   = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    assign fifo_head  = fifo_mem[rd_ptr_q];

    // The output register may take new data when it is empty or its write completes
    assign out_free   = !mem_wren_q || !memBusy;
    assign pop        = (state_q == IDLE) && out_free && !fifo_empty;
    assign fill_start = (state_q == IDLE) && fill_pending_q && fifo_empty && out_free;

    always_comb begin
        state_d        = state_q;
        mem_wren_d     = mem_wren_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        fill_done_d    = 1'b0;
        fill_pending_d = fill_pending_q;
        fill_color_d   = fill_color_q;
        case (state_q)
            IDLE: begin
                if (fillReq && !fill_pending_q) begin
                    fill_pending_d = 1'b1;
                    fill_color_d   = fillColor;
                end
                if (pop) begin
                    mem_wren_d = 1'b1;
                    mem_addr_d = fifo_head[17:3];
                    mem_data_d = fifo_head[2:0];
                end else if (fill_start) begin
                    state_d    = FILL;
                    mem_wren_d = 1'b1;
                    mem_addr_d = '0;
                    mem_data_d = fill_color_q;
                end else if (out_free) begin
                    mem_wren_d = 1'b0;
                end
            end
            FILL: begin
                if (!memBusy) begin
                    if (mem_addr_q == 15'(LAST_ADDR)) begin
                        state_d        = IDLE;
                        mem_wren_d     = 1'b0;
                        fill_done_d    = 1'b1;
                        fill_pending_d = 1'b0;
                    end else begin
                        mem_addr_d = mem_addr_q + 15'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is left unreset; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pix_addr, color};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            mem_wren_q     <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            fill_done_q    <= 1'b0;
            fill_pending_q <= 1'b0;
            fill_color_q   <= '0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            mem_wren_q     <= mem_wren_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            fill_done_q    <= fill_done_d;
            fill_pending_q <= fill_pending_d;
            fill_color_q   <= fill_color_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop && (drop_count_q != 8'hFF)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign memWren   = mem_wren_q;
    assign memAddr   = mem_addr_q;
    assign memData   = mem_data_q;
    assign fillDone  = fill_done_q;
    assign dropCount = drop_count_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Scoreboard bench for pixel_write_buffer: stimulus pushes expected framebuffer
// writes into a queue, a negedge monitor pops and compares each completed write.
module tb_pixel_write_buffer;
    logic        clk = 1'b0;
    logic        reset, plot, fillReq, memBusy;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color, fillColor;
    logic        ready, memWren, fillDone;
    logic [14:0] memAddr;
    logic [2:0]  memData;
    logic [7:0]  dropCount;

    pixel_write_buffer dut (
        .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .color(color),
        .ready(ready), .fillReq(fillReq), .fillColor(fillColor), .memBusy(memBusy),
        .memAddr(memAddr), .memData(memData), .memWren(memWren),
        .fillDone(fillDone), .dropCount(dropCount)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [17:0] sb [$];
    int          drop_exp = 0;
    int          fill_done_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] prev_out = '0;
    logic        rand_busy = 1'b0;
    logic        quiet = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: completed writes, stall stability and fill-done pulses
    always @(negedge clk) begin
        logic [17:0] exp_v;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!memWren || ({memAddr, memData} != prev_out)) begin
                    errors++;
                    $display("FAIL hold: got wren=%0d addr=%0d data=%0d expected wren=1 addr=%0d data=%0d",
                             memWren, memAddr, memData, prev_out[17:3], prev_out[2:0]);
                end
            end
            if (memWren && !memBusy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0d expected no write", memAddr, memData);
                end else begin
                    exp_v = sb.pop_front();
                    if ({memAddr, memData} != exp_v) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                 memAddr, memData, exp_v[17:3], exp_v[2:0]);
                    end else if (!quiet) begin
                        $display("write addr=%0d data=%0d ok", memAddr, memData);
                    end
                end
            end
            if (fillDone) begin
                fill_done_cnt++;
                check("fill_done_after_all_writes", sb.size(), 0);
            end
            prev_stall = memWren && memBusy;
            prev_out   = {memAddr, memData};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_busy) memBusy = ($urandom_range(0, 3) == 0);
    endtask

    task automatic model_pixel(input int px, input int py, input int pc);
        if (px >= 160 || py >= 120) begin
            if (drop_exp < 255) drop_exp++;
        end else begin
            sb.push_back({15'(py * 160 + px), 3'(pc)});
        end
    endtask

    task automatic send_pixel(input int px, input int py, input int pc);
        logic acc;
        int   budget;
        budget = 0;
        x = 8'(px); y = 7'(py); color = 3'(pc); plot = 1'b1;
        forever begin
            acc = ready;
            step();
            if (acc) begin
                model_pixel(px, py, pc);
                break;
            end
            budget++;
            if (budget > 200) begin
                check("send_timeout", 1, 0);
                break;
            end
        end
        plot = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (sb.size() != 0 || memWren) begin
            step();
            budget++;
            if (budget > 30000) begin
                check("drain_timeout", sb.size(), 0);
                break;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; plot = 1'b0; fillReq = 1'b0; memBusy = 1'b0;
        sb.delete();
        step();
        step();
        check("rst_ready_low", ready, 0);
        check("rst_wren", memWren, 0);
        check("rst_addr", memAddr, 0);
        check("rst_data", memData, 0);
        check("rst_filldone", fillDone, 0);
        check("rst_dropcount", dropCount, 0);
        reset = 1'b0;
        drop_exp = 0;
        #1;
        check("rst_ready_high", ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        int budget;
        reset = 1'b1; plot = 1'b0; fillReq = 1'b0; memBusy = 1'b0;
        x = '0; y = '0; color = '0; fillColor = '0;
        apply_reset();

        // Single pixel latency
        x = 8'd5; y = 7'd2; color = 3'b101; plot = 1'b1;
        check("single_ready", ready, 1);
        sb.push_back({15'd325, 3'd5});
        step();
        plot = 1'b0;
        check("single_n1_wren", memWren, 0);
        step();
        check("single_n2_wren", memWren, 1);
        check("single_n2_addr", memAddr, 325);
        check("single_n2_data", memData, 5);
        step();
        check("single_n3_wren", memWren, 0);

        // Backpressure: one pixel in the output stage, four in the FIFO
        memBusy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", ready, 1);
            x = 8'(i * 10 + 3); y = 7'(i + 1); color = 3'(i + 1); plot = 1'b1;
            model_pixel(i * 10 + 3, i + 1, i + 1);
            step();
        end
        plot = 1'b0;
        check("bp_full_ready", ready, 0);
        repeat (3) step();
        check("bp_hold_wren", memWren, 1);
        check("bp_hold_addr", memAddr, 163);
        memBusy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_stream_wren", memWren, 1);
            step();
        end
        check("bp_stream_end", memWren, 0);

        // Corner addresses
        send_pixel(159, 119, 7);
        send_pixel(0, 0, 6);
        wait_drain();

        // Randomized traffic with random stalls
        rand_busy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send_pixel($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_busy = 1'b0;
        memBusy = 1'b0;
        wait_drain();
        check("rand_dropcount", dropCount, drop_exp);

        // Out-of-range pixels and saturation
        apply_reset();
        send_pixel(160, 0, 1);
        send_pixel(0, 120, 2);
        send_pixel(255, 127, 3);
        repeat (4) step();
        check("oor_dropcount3", dropCount, drop_exp);
        check("oor_no_writes", sb.size(), 0);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) send_pixel($urandom_range(160, 255), $urandom_range(0, 127), 1);
            else            send_pixel($urandom_range(0, 255), $urandom_range(120, 127), 1);
        end
        repeat (4) step();
        check("oor_dropcount_sat", dropCount, drop_exp);

        // Fill behind two queued pixels, fillReq alongside the second plot
        x = 8'd10; y = 7'd10; color = 3'd1; plot = 1'b1;
        check("fill_p1_ready", ready, 1);
        model_pixel(10, 10, 1);
        step();
        x = 8'd20; y = 7'd20; color = 3'd2; fillReq = 1'b1; fillColor = 3'b000;
        check("fill_p2_ready", ready, 1);
        model_pixel(20, 20, 2);
        for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 3'b000});
        step();
        plot = 1'b0; fillReq = 1'b0;
        check("fill_pending_ready", ready, 0);
        quiet = 1'b1;
        repeat (100) step();
        fillReq = 1'b1; fillColor = 3'b111;
        step();
        fillReq = 1'b0;
        budget = 0;
        while (fill_done_cnt == 0 && budget < 25000) begin
            step();
            budget++;
        end
        check("fill_done_seen", fill_done_cnt, 1);
        check("fill_after_ready", ready, 1);
        check("fill_after_wren", memWren, 0);
        repeat (10) step();
        check("fill_done_once", fill_done_cnt, 1);
        check("fill_queue_empty", sb.size(), 0);

        // Reset in the middle of a fill
        saved = fill_done_cnt;
        fillReq = 1'b1; fillColor = 3'b110;
        for (int a = 0; a < 19200; a++) sb.push_back({15'(a), 3'b110});
        step();
        fillReq = 1'b0;
        budget = 0;
        while (!(memWren && memAddr == 15'd1000) && budget < 3000) begin
            step();
            budget++;
        end
        memBusy = 1'b1;
        check("midfill_reached_1000", memAddr, 1000);
        reset = 1'b1;
        step();
        check("midfill_wren", memWren, 0);
        check("midfill_filldone", fillDone, 0);
        check("midfill_ready_in_reset", ready, 0);
        reset = 1'b0;
        sb.delete();
        drop_exp = 0;
        memBusy = 1'b0;
        #1;
        check("midfill_ready_after", ready, 1);
        repeat (30) step();
        check("midfill_no_done", fill_done_cnt, saved);
        check("midfill_dropcount", dropCount, drop_exp);
        quiet = 1'b0;

        // Pixel after the aborted fill still works
        send_pixel(1, 1, 4);
        wait_drain();
        check("post_reset_queue", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
